// File: rtl/detection_result_collector.sv
// Tracks cascade progress of one detection window and queues accepted windows
// ({X,Y,score}) in a show-ahead FIFO for the host, with a saturating face count.
module detection_result_collector #(
  parameter int NUM_STAGES = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int COORD_W    = 10,
  parameter int DATA_W     = 32
) (
  input  logic               iClk,
  input  logic               iReset,
  input  logic               iClear,
  input  logic               iStart_Win,
  input  logic [COORD_W-1:0] iWin_X,
  input  logic [COORD_W-1:0] iWin_Y,
  input  logic               iWrreq_OM,
  input  logic [DATA_W-1:0]  iData_out,
  input  logic               iFinish_Stage,
  input  logic               iPass,
  input  logic               iRdreq,
  output logic               oBusy,
  output logic [3:0]         oStage,
  output logic               oWin_Done,
  output logic               oAccept,
  output logic [COORD_W-1:0] oFace_X,
  output logic [COORD_W-1:0] oFace_Y,
  output logic [DATA_W-1:0]  oScore,
  output logic               oEmpty,
  output logic               oFull,
  output logic               oOverflow,
  output logic [15:0]        oFace_Count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 2*COORD_W + DATA_W;
  localparam logic [3:0]    LAST_STAGE = 4'(NUM_STAGES - 1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL   = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [3:0]           stage_q, stage_d;
  logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic [DATA_W-1:0]    score_q, score_d;
  logic                 accept_q, accept_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]          cnt_q, cnt_d;
  logic                 overflow_q, overflow_d;
  logic [15:0]          face_cnt_q, face_cnt_d;
  logic [EW-1:0]        mem_q [FIFO_DEPTH];

  logic                 in_eval, is_last, accept_push, fifo_full, fifo_empty;
  logic                 pop, wr_en;
  logic [DATA_W-1:0]    push_score;
  logic [EW-1:0]        wr_dat, head_dat;

  assign in_eval     = (state_q == S_EVAL);
  assign is_last     = (stage_q == LAST_STAGE);
  assign accept_push = in_eval & iFinish_Stage & iPass & is_last;
  assign fifo_full   = (cnt_q == CNT_FULL);
  assign fifo_empty  = (cnt_q == '0);
  // A score arriving together with the final verdict must not be missed.
  assign push_score  = iWrreq_OM ? iData_out : score_q;
  assign wr_dat      = {x_q, y_q, push_score};
  assign pop         = iRdreq & ~fifo_empty;
  assign wr_en       = accept_push & (~fifo_full | pop) & ~iClear;
  assign head_dat    = mem_q[rd_ptr_q];

  // FSM: state register
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (iStart_Win) state_d = S_EVAL;
      S_EVAL: if (iFinish_Stage && (!iPass || is_last)) state_d = S_DONE;
      S_DONE: state_d = iStart_Win ? S_EVAL : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    oBusy     = (state_q == S_EVAL);
    oWin_Done = (state_q == S_DONE);
  end

  // Window context
  always_comb begin
    stage_d  = stage_q;
    x_d      = x_q;
    y_d      = y_q;
    score_d  = score_q;
    accept_d = accept_q;
    if (iStart_Win && !in_eval) begin
      stage_d = '0;
      x_d     = iWin_X;
      y_d     = iWin_Y;
      score_d = '0;
    end
    if (in_eval) begin
      if (iWrreq_OM) score_d = iData_out;
      if (iFinish_Stage) begin
        if (!iPass)       accept_d = 1'b0;
        else if (is_last) accept_d = 1'b1;
        else              stage_d  = stage_q + 4'd1;
      end
    end
  end

  // FIFO bookkeeping, overflow and face count; clear overrides everything here.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    face_cnt_d = face_cnt_q;
    if (iClear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
      overflow_d = 1'b0;
      face_cnt_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (wr_en && !pop)      cnt_d = cnt_q + CNT_ONE;
      else if (!wr_en && pop) cnt_d = cnt_q - CNT_ONE;
      if (accept_push && fifo_full && !pop) overflow_d = 1'b1;
      if (accept_push && face_cnt_q != 16'hFFFF) face_cnt_d = face_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      stage_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      score_q    <= '0;
      accept_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      face_cnt_q <= '0;
    end else begin
      stage_q    <= stage_d;
      x_q        <= x_d;
      y_q        <= y_d;
      score_q    <= score_d;
      accept_q   <= accept_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      face_cnt_q <= face_cnt_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge iClk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_dat;
  end

  assign oStage      = stage_q;
  assign oAccept     = accept_q;
  assign oEmpty      = fifo_empty;
  assign oFull       = fifo_full;
  assign oOverflow   = overflow_q;
  assign oFace_Count = face_cnt_q;
  assign oFace_X     = fifo_empty ? '0 : head_dat[EW-1 -: COORD_W];
  assign oFace_Y     = fifo_empty ? '0 : head_dat[DATA_W +: COORD_W];
  assign oScore      = fifo_empty ? '0 : head_dat[DATA_W-1:0];

endmodule

// File: tb/tb_detection_result_collector.sv
// Directed bench for detection_result_collector (NUM_STAGES=4, FIFO_DEPTH=16).
module tb_detection_result_collector;

  logic        iClk = 1'b0;
  logic        iReset = 1'b1;
  logic        iClear = 1'b0;
  logic        iStart_Win = 1'b0;
  logic [9:0]  iWin_X = '0;
  logic [9:0]  iWin_Y = '0;
  logic        iWrreq_OM = 1'b0;
  logic [31:0] iData_out = '0;
  logic        iFinish_Stage = 1'b0;
  logic        iPass = 1'b0;
  logic        iRdreq = 1'b0;
  logic        oBusy, oWin_Done, oAccept, oEmpty, oFull, oOverflow;
  logic [3:0]  oStage;
  logic [9:0]  oFace_X, oFace_Y;
  logic [31:0] oScore;
  logic [15:0] oFace_Count;

  int tests_run = 0;
  int tests_failed = 0;

  detection_result_collector #(
    .NUM_STAGES(4), .FIFO_DEPTH(16), .COORD_W(10), .DATA_W(32)
  ) dut (
    .iClk(iClk), .iReset(iReset), .iClear(iClear),
    .iStart_Win(iStart_Win), .iWin_X(iWin_X), .iWin_Y(iWin_Y),
    .iWrreq_OM(iWrreq_OM), .iData_out(iData_out),
    .iFinish_Stage(iFinish_Stage), .iPass(iPass), .iRdreq(iRdreq),
    .oBusy(oBusy), .oStage(oStage), .oWin_Done(oWin_Done), .oAccept(oAccept),
    .oFace_X(oFace_X), .oFace_Y(oFace_Y), .oScore(oScore),
    .oEmpty(oEmpty), .oFull(oFull), .oOverflow(oOverflow),
    .oFace_Count(oFace_Count)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic start_win(input logic [9:0] x, input logic [9:0] y);
    iStart_Win = 1'b1; iWin_X = x; iWin_Y = y;
    tick();
    iStart_Win = 1'b0;
  endtask

  task automatic stage(input logic pass, input logic wr, input logic [31:0] sc, input logic rd);
    iFinish_Stage = 1'b1; iPass = pass; iWrreq_OM = wr; iData_out = sc; iRdreq = rd;
    tick();
    iFinish_Stage = 1'b0; iPass = 1'b0; iWrreq_OM = 1'b0; iRdreq = 1'b0;
  endtask

  task automatic full_window(input logic [9:0] x, input logic [9:0] y, input logic [31:0] sc);
    start_win(x, y);
    repeat (3) stage(1'b1, 1'b0, 32'h0, 1'b0);
    stage(1'b1, 1'b1, sc, 1'b0);
    tick();
  endtask

  task automatic pop();
    iRdreq = 1'b1;
    tick();
    iRdreq = 1'b0;
  endtask

  task automatic clear();
    iClear = 1'b1;
    tick();
    iClear = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (2) tick();
    check("rst_busy", 64'(oBusy), 64'd0);
    check("rst_stage", 64'(oStage), 64'd0);
    check("rst_done", 64'(oWin_Done), 64'd0);
    check("rst_accept", 64'(oAccept), 64'd0);
    check("rst_empty", 64'(oEmpty), 64'd1);
    check("rst_full", 64'(oFull), 64'd0);
    check("rst_head", 64'({oFace_X, oFace_Y, oScore}), 64'd0);
    check("rst_ovf", 64'(oOverflow), 64'd0);
    check("rst_cnt", 64'(oFace_Count), 64'd0);
    iReset = 1'b0;
    tick();

    // Accepted window, last score arrives with final verdict
    start_win(10'd5, 10'd9);
    check("t1_busy", 64'(oBusy), 64'd1);
    stage(1'b1, 1'b1, 32'h1111, 1'b0);
    stage(1'b1, 1'b1, 32'h2222, 1'b0);
    stage(1'b1, 1'b1, 32'h3333, 1'b0);
    check("t1_stage3", 64'(oStage), 64'd3);
    stage(1'b1, 1'b1, 32'h1234, 1'b0);
    check("t1_done", 64'(oWin_Done), 64'd1);
    check("t1_accept", 64'(oAccept), 64'd1);
    check("t1_busy_done", 64'(oBusy), 64'd0);
    check("t1_empty", 64'(oEmpty), 64'd0);
    check("t1_x", 64'(oFace_X), 64'd5);
    check("t1_y", 64'(oFace_Y), 64'd9);
    check("t1_score", 64'(oScore), 64'h1234);
    check("t1_cnt", 64'(oFace_Count), 64'd1);
    tick();
    check("t1_done_pulse", 64'(oWin_Done), 64'd0);
    check("t1_accept_hold", 64'(oAccept), 64'd1);
    pop();
    check("t1_pop_empty", 64'(oEmpty), 64'd1);

    // Reject at stage 1, then back-to-back start from DONE
    start_win(10'd3, 10'd4);
    check("t2_stage0", 64'(oStage), 64'd0);
    stage(1'b1, 1'b0, 32'h0, 1'b0);
    check("t2_stage1", 64'(oStage), 64'd1);
    stage(1'b0, 1'b0, 32'h0, 1'b0);
    check("t2_done", 64'(oWin_Done), 64'd1);
    check("t2_accept", 64'(oAccept), 64'd0);
    check("t2_stage_reached", 64'(oStage), 64'd1);
    check("t2_empty", 64'(oEmpty), 64'd1);
    check("t2_cnt", 64'(oFace_Count), 64'd1);
    start_win(10'd11, 10'd12);
    check("t2_b2b_busy", 64'(oBusy), 64'd1);
    check("t2_b2b_stage", 64'(oStage), 64'd0);
    stage(1'b0, 1'b0, 32'h0, 1'b0);
    check("t2_b2b_done", 64'(oWin_Done), 64'd1);
    tick();

    // Ignored controls: finish/write in IDLE, start during EVAL; held score used
    iFinish_Stage = 1'b1; iPass = 1'b1; iWrreq_OM = 1'b1; iData_out = 32'hDEAD;
    tick();
    iFinish_Stage = 1'b0; iPass = 1'b0; iWrreq_OM = 1'b0;
    check("t5_idle_busy", 64'(oBusy), 64'd0);
    check("t5_idle_done", 64'(oWin_Done), 64'd0);
    check("t5_idle_empty", 64'(oEmpty), 64'd1);
    start_win(10'd7, 10'd8);
    iWrreq_OM = 1'b1; iData_out = 32'hABCD;
    tick();
    iWrreq_OM = 1'b0;
    stage(1'b1, 1'b0, 32'h0, 1'b0);
    start_win(10'd1, 10'd2);
    check("t5_eval_busy", 64'(oBusy), 64'd1);
    check("t5_eval_stage", 64'(oStage), 64'd1);
    repeat (2) stage(1'b1, 1'b0, 32'h0, 1'b0);
    stage(1'b1, 1'b0, 32'h0, 1'b0);
    check("t5_done", 64'(oWin_Done), 64'd1);
    check("t5_x", 64'(oFace_X), 64'd7);
    check("t5_y", 64'(oFace_Y), 64'd8);
    check("t5_score", 64'(oScore), 64'hABCD);
    check("t5_cnt", 64'(oFace_Count), 64'd2);
    tick();
    pop();

    // 17 accepts into a 16-deep FIFO
    clear();
    check("t3_clr_cnt", 64'(oFace_Count), 64'd0);
    for (int i = 0; i < 17; i++) begin
      full_window(10'(i), 10'(i + 100), 32'h1000 + 32'(i));
      if (i == 15) begin
        check("t3_full16", 64'(oFull), 64'd1);
        check("t3_noovf16", 64'(oOverflow), 64'd0);
      end
    end
    check("t3_ovf", 64'(oOverflow), 64'd1);
    check("t3_full", 64'(oFull), 64'd1);
    check("t3_cnt", 64'(oFace_Count), 64'd17);
    for (int i = 0; i < 16; i++) begin
      check("t3_pop_x", 64'(oFace_X), 64'(i));
      check("t3_pop_y", 64'(oFace_Y), 64'(i + 100));
      check("t3_pop_score", 64'(oScore), 64'h1000 + 64'(i));
      pop();
    end
    check("t3_drained", 64'(oEmpty), 64'd1);
    check("t3_ovf_sticky", 64'(oOverflow), 64'd1);

    // Full FIFO, accept and pop in the same cycle
    clear();
    check("t4_clr_ovf", 64'(oOverflow), 64'd0);
    for (int i = 0; i < 16; i++) full_window(10'(20 + i), 10'(40 + i), 32'h2000 + 32'(i));
    start_win(10'd50, 10'd51);
    repeat (3) stage(1'b1, 1'b0, 32'h0, 1'b0);
    stage(1'b1, 1'b1, 32'h5050, 1'b1);
    check("t4_full", 64'(oFull), 64'd1);
    check("t4_noovf", 64'(oOverflow), 64'd0);
    check("t4_head", 64'(oFace_X), 64'd21);
    check("t4_cnt", 64'(oFace_Count), 64'd17);
    tick();
    repeat (15) pop();
    check("t4_tail_x", 64'(oFace_X), 64'd50);
    check("t4_tail_y", 64'(oFace_Y), 64'd51);
    check("t4_tail_score", 64'(oScore), 64'h5050);
    pop();
    check("t4_empty", 64'(oEmpty), 64'd1);

    // Clear in the same cycle as an accept: accept lost
    clear();
    start_win(10'd30, 10'd31);
    repeat (3) stage(1'b1, 1'b0, 32'h0, 1'b0);
    iClear = 1'b1;
    stage(1'b1, 1'b1, 32'h3030, 1'b0);
    iClear = 1'b0;
    check("t7_done", 64'(oWin_Done), 64'd1);
    check("t7_accept", 64'(oAccept), 64'd1);
    check("t7_empty", 64'(oEmpty), 64'd1);
    check("t7_cnt", 64'(oFace_Count), 64'd0);
    tick();

    // Async reset during stage 2
    full_window(10'd60, 10'd61, 32'h77);
    start_win(10'd62, 10'd63);
    repeat (2) stage(1'b1, 1'b0, 32'h0, 1'b0);
    check("t6_stage2", 64'(oStage), 64'd2);
    iReset = 1'b1;
    #1;
    check("t6_busy", 64'(oBusy), 64'd0);
    check("t6_stage", 64'(oStage), 64'd0);
    check("t6_empty", 64'(oEmpty), 64'd1);
    check("t6_cnt", 64'(oFace_Count), 64'd0);
    check("t6_accept", 64'(oAccept), 64'd0);
    tick();
    iReset = 1'b0;
    full_window(10'd70, 10'd71, 32'h99);
    check("t6_new_x", 64'(oFace_X), 64'd70);
    check("t6_new_score", 64'(oScore), 64'h99);
    check("t6_new_cnt", 64'(oFace_Count), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
